// File: rtl/cmd_seq.sv
// Command sequencer: queues 16-bit commands and plays them one at a time to a
// RemoteComm link, waiting for send completion and an ACK byte per command.
module cmd_seq #(
  parameter int unsigned DEPTH      = 8,
  parameter logic [23:0] TMO_CYCLES = 24'd10_000_000,
  parameter logic [7:0]  ACK        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_cmd,
  input  logic        start,
  input  logic        abort,
  input  logic        clr_err,
  output logic [15:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        ovfl,
  output logic [7:0]  ack_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_SENT, WAIT_RESP, ERR} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [23:0]   tmo_cnt;
  logic          pop, flush, push_ok, tmo_hit, launch_entry;
  logic [15:0]   head_nxt;
  logic [1:0]    err_code_nxt;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // NOTE: every signal driven here gets a default first, so no latches appear.
  always_comb begin
    flush   = abort || (state == ERR && clr_err);
    pop     = (state == WAIT_RESP) && resp_rdy && (resp == ACK) && !abort;
    push_ok = push && !flush && (!full || pop);

    count_nxt = count;
    if (flush)                count_nxt = '0;
    else if (push_ok && !pop) count_nxt = count + CW'(1);
    else if (pop && !push_ok) count_nxt = count - CW'(1);

    // The budget spans WAIT_SENT and WAIT_RESP together, so use >= to catch
    // a command that entered WAIT_RESP on the last allowed cycle.
    tmo_hit = (tmo_cnt >= TMO_CYCLES - 24'd1);

    state_nxt    = state;
    err_code_nxt = err_code;
    case (state)
      IDLE:      if (start && !empty) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_SENT;
      WAIT_SENT: begin
        if (cmd_sent) begin
          state_nxt = WAIT_RESP;
        end else if (tmo_hit) begin
          state_nxt    = ERR;
          err_code_nxt = 2'b10;
        end
      end
      WAIT_RESP: begin
        if (resp_rdy) begin
          if (resp == ACK) begin
            state_nxt = (count_nxt == '0) ? IDLE : LAUNCH;
          end else begin
            state_nxt    = ERR;
            err_code_nxt = 2'b01;
          end
        end else if (tmo_hit) begin
          state_nxt    = ERR;
          err_code_nxt = 2'b10;
        end
      end
      ERR: begin
        if (clr_err) begin
          state_nxt    = IDLE;
          err_code_nxt = 2'b00;
        end
      end
      default:   state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt    = IDLE;
      err_code_nxt = 2'b00;
    end

    launch_entry = (state_nxt == LAUNCH);
    // After a pop the next head is one slot on, unless a single entry is being
    // replaced by a word pushed this very cycle.
    if (pop) head_nxt = (count == CW'(1)) ? push_cmd : mem[rd_ptr + AW'(1)];
    else     head_nxt = mem[rd_ptr];
  end

  // NOTE: storage is left unreset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tmo_cnt  <= '0;
      cmd      <= 16'h0000;
      send_cmd <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      ovfl     <= 1'b0;
      ack_cnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
      end

      if (state == LAUNCH)                                 tmo_cnt <= '0;
      else if (state == WAIT_SENT || state == WAIT_RESP)   tmo_cnt <= tmo_cnt + 24'd1;

      if (launch_entry) cmd <= head_nxt;
      send_cmd <= launch_entry;
      done     <= pop && (count_nxt == '0);
      busy     <= (state_nxt != IDLE);
      err      <= (state_nxt == ERR);
      err_code <= err_code_nxt;

      if (!abort && state == ERR && clr_err)   ovfl <= 1'b0;
      else if (push && !flush && full && !pop) ovfl <= 1'b1;

      if (!abort && state == IDLE && start && !empty) ack_cnt <= 8'd0;
      else if (pop)                                   ack_cnt <= ack_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cmd_seq.sv
// Directed bench for cmd_seq: a queue of expected commands is filled as words
// are pushed and consumed as the DUT launches and acknowledges them.
module tb_cmd_seq;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  ACK_B = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, start, abort, clr_err, cmd_sent, resp_rdy;
  logic [15:0] push_cmd;
  logic [7:0]  resp;
  logic [15:0] cmd;
  logic        send_cmd, full, empty, busy, done, err, ovfl;
  logic [1:0]  err_code;
  logic [7:0]  ack_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          send_cnt = 0;
  int          done_cnt = 0;
  logic [15:0] q[$];

  cmd_seq #(.DEPTH(DEPTH), .TMO_CYCLES(24'd100), .ACK(ACK_B)) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .start(start),
    .abort(abort), .clr_err(clr_err), .cmd(cmd), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .full(full),
    .empty(empty), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .ovfl(ovfl), .ack_cnt(ack_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_cmd === 1'b1) send_cnt++;
    if (done === 1'b1)     done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [15:0] w);
    push = 1'b1; push_cmd = w;
    tick();
    push = 1'b0;
    if (q.size() < DEPTH) q.push_back(w);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_launch(input string tag);
    int n = 0;
    while (send_cmd !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_launch"}, 32'(send_cmd), 32'd1);
    if (q.size() > 0) check({tag, "_cmd"}, 32'(cmd), 32'(q[0]));
  endtask

  task automatic serve(input string tag, input logic [7:0] r);
    wait_launch(tag);
    tick();
    check({tag, "_strobe_width"}, 32'(send_cmd), 32'd0);
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    resp_rdy = 1'b1; resp = r; tick(); resp_rdy = 1'b0;
    if (r == ACK_B && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd"},      32'(cmd),      32'h0);
    check({tag, "_send"},     32'(send_cmd), 32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_ovfl"},     32'(ovfl),     32'd0);
    check({tag, "_ack_cnt"},  32'(ack_cnt),  32'd0);
    check({tag, "_empty"},    32'(empty),    32'd1);
    check({tag, "_full"},     32'(full),     32'd0);
  endtask

  initial begin
    int sends0, dones0;
    rst = 1'b1; push = 1'b0; push_cmd = '0; start = 1'b0; abort = 1'b0;
    clr_err = 1'b0; cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // start with an empty FIFO is ignored
    do_start();
    tick();
    check("empty_start_busy", 32'(busy), 32'd0);
    check("empty_start_done_cnt", 32'(done_cnt), 32'd0);

    // normal tour, with a stray response during WAIT_SENT
    do_push(16'h2000); do_push(16'h4001); do_push(16'h3002);
    check("tour_empty", 32'(empty), 32'd0);
    sends0 = send_cnt; dones0 = done_cnt;
    do_start();
    wait_launch("tour0");
    check("tour_busy", 32'(busy), 32'd1);
    tick();
    resp_rdy = 1'b1; resp = ACK_B; tick(); resp_rdy = 1'b0;
    check("stray_resp_ack_cnt", 32'(ack_cnt), 32'd0);
    check("stray_resp_no_launch", 32'(send_cmd), 32'd0);
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    resp_rdy = 1'b1; resp = ACK_B; tick(); resp_rdy = 1'b0;
    void'(q.pop_front());
    serve("tour1", ACK_B);
    serve("tour2", ACK_B);
    check("tour_done", 32'(done), 32'd1);
    check("tour_busy_falls", 32'(busy), 32'd0);
    check("tour_ack_cnt", 32'(ack_cnt), 32'd3);
    check("tour_empty_end", 32'(empty), 32'd1);
    tick();
    check("tour_done_pulse", 32'(done), 32'd0);
    check("tour_send_pulses", 32'(send_cnt - sends0), 32'd3);
    check("tour_done_pulses", 32'(done_cnt - dones0), 32'd1);

    // NAK leaves the head queued until clr_err flushes it
    do_push(16'h1111);
    do_start();
    check("nak_ack_cleared", 32'(ack_cnt), 32'd0);
    serve("nak", 8'h5A);
    check("nak_err", 32'(err), 32'd1);
    check("nak_code", 32'(err_code), 32'd1);
    check("nak_not_empty", 32'(empty), 32'd0);
    do_push(16'h7777);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    q.delete();
    check("clr_err_err", 32'(err), 32'd0);
    check("clr_err_code", 32'(err_code), 32'd0);
    check("clr_err_empty", 32'(empty), 32'd1);
    check("clr_err_busy", 32'(busy), 32'd0);

    // timeout exactly 100 cycles after WAIT_SENT entry
    do_push(16'h2222);
    do_start();
    wait_launch("tmo");
    tick();
    repeat (99) tick();
    check("tmo_not_yet", 32'(err), 32'd0);
    tick();
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_code", 32'(err_code), 32'd2);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    q.delete();

    // cmd_sent on the timeout cycle wins
    do_push(16'h3333);
    do_start();
    wait_launch("tmo_race");
    tick();
    repeat (99) tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    check("tmo_race_err", 32'(err), 32'd0);
    check("tmo_race_busy", 32'(busy), 32'd1);
    resp_rdy = 1'b1; resp = ACK_B; tick(); resp_rdy = 1'b0;
    void'(q.pop_front());
    check("tmo_race_done", 32'(done), 32'd1);
    check("tmo_race_ack_cnt", 32'(ack_cnt), 32'd1);

    // overflow, then push coincident with an ACK pop while full
    for (int i = 0; i <= DEPTH; i++) do_push(16'h5000 + 16'(i));
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_flag", 32'(ovfl), 32'd1);
    do_start();
    wait_launch("ovf0");
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    resp_rdy = 1'b1; resp = ACK_B; push = 1'b1; push_cmd = 16'h5005;
    tick();
    resp_rdy = 1'b0; push = 1'b0;
    void'(q.pop_front());
    q.push_back(16'h5005);
    check("simul_full", 32'(full), 32'd1);
    check("simul_ovfl", 32'(ovfl), 32'd1);
    for (int i = 1; i <= DEPTH; i++) serve($sformatf("ovf%0d", i), ACK_B);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_ack_cnt", 32'(ack_cnt), 32'(DEPTH + 1));

    // abort in WAIT_RESP
    do_push(16'h6000); do_push(16'h6001);
    do_start();
    wait_launch("abort");
    tick();
    cmd_sent = 1'b1; tick(); cmd_sent = 1'b0;
    dones0 = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0;
    q.delete();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_empty", 32'(empty), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    tick();
    check("abort_no_done", 32'(done_cnt - dones0), 32'd0);

    // asynchronous reset in the middle of LAUNCH
    do_push(16'h7000);
    do_start();
    check("pre_rst_launch", 32'(send_cmd), 32'd1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("mid_rst");
    tick(); tick();
    rst = 1'b0;
    q.delete();
    sends0 = send_cnt;
    cmd_sent = 1'b1; resp_rdy = 1'b1; resp = ACK_B;
    repeat (5) tick();
    cmd_sent = 1'b0; resp_rdy = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_no_launch", 32'(send_cnt - sends0), 32'd0);
    check("post_rst_ack_cnt", 32'(ack_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_seq.md
CMD_SEQ -- requirements
Module: cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning command FIFO depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter TMO_CYCLES, default 24'd10_000_000, meaning the clock cycles allowed per command before timeout (1..2^24-1).
REQ-003 SHALL have parameter ACK, default 8'hA5, meaning the response byte that marks a completed command.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, declared first as: clk in 1 (system clock, rising edge); rst in 1 (asynchronous active-high reset).
REQ-005 SHALL have port push in 1: enqueue push_cmd this cycle.
REQ-006 SHALL have port push_cmd in 16: command word to enqueue.
REQ-007 SHALL have port start in 1: begin draining the FIFO.
REQ-008 SHALL have port abort in 1: stop, flush, return to idle.
REQ-009 SHALL have port clr_err in 1: leave the error state.
REQ-010 SHALL have port cmd out 16: command presented to the RemoteComm cmd input.
REQ-011 SHALL have port send_cmd out 1: single-cycle launch strobe to RemoteComm.
REQ-012 SHALL have port cmd_sent in 1: RemoteComm reports transmission complete.
REQ-013 SHALL have port resp_rdy in 1: RemoteComm reports a response byte is valid.
REQ-014 SHALL have port resp in 8: response byte.
REQ-015 SHALL have port full out 1: FIFO holds DEPTH entries.
REQ-016 SHALL have port empty out 1: FIFO holds 0 entries.
REQ-017 SHALL have port busy out 1: state is not IDLE.
REQ-018 SHALL have port done out 1: one-cycle pulse when the FIFO drains successfully.
REQ-019 SHALL have port err out 1: level, high while in ERR.
REQ-020 SHALL have port err_code out 2: 00 none, 01 NAK, 10 timeout.
REQ-021 SHALL have port ovfl out 1: sticky flag set by a push while full.
REQ-022 SHALL have port ack_cnt out 8: count of acknowledged commands since the last start.

Function
REQ-023 SHALL implement the states IDLE, LAUNCH, WAIT_SENT, WAIT_RESP and ERR.
REQ-024 SHALL, in IDLE, go to LAUNCH on start with !empty; start with empty SHALL be ignored, giving no done.
REQ-025 SHALL clear ack_cnt to 0 on the accepted start.
REQ-026 SHALL assert send_cmd for exactly the one cycle spent in LAUNCH and then go to WAIT_SENT.
REQ-027 SHALL register cmd from the FIFO head on entry to LAUNCH and hold it stable until WAIT_RESP exits.
REQ-028 SHALL, in WAIT_SENT, go to WAIT_RESP on cmd_sent.
REQ-029 SHALL ignore resp_rdy while in WAIT_SENT.
REQ-030 SHALL, in WAIT_RESP on resp_rdy with resp==ACK, pop the head and increment ack_cnt (wrapping 255 to 0); then, if the FIFO is empty after the pop, go to IDLE with done pulsed that cycle, else go to LAUNCH.
REQ-031 SHALL, in WAIT_RESP on resp_rdy with resp!=ACK, go to ERR with err_code=01, leaving the head unpopped.
REQ-032 SHALL clear the timeout counter on entry to WAIT_SENT and count every cycle in WAIT_SENT and WAIT_RESP; on reaching TMO_CYCLES it SHALL go to ERR with err_code=10.
REQ-033 SHALL give a cmd_sent or resp_rdy arriving on the timeout cycle priority over the timeout.
REQ-034 SHALL hold ERR until clr_err, then flush the FIFO, clear err_code and ovfl, and go to IDLE.
REQ-035 SHALL accept abort in any state: the next state is IDLE, the FIFO is flushed, done is not pulsed, err_code is cleared, and send_cmd is low that cycle.
REQ-036 SHALL give abort priority over every other input.
REQ-037 SHALL accept push in any state including ERR; the entry is written at the tail.
REQ-038 SHALL, for push while full, drop the word, leave the FIFO unchanged, and set ovfl.
REQ-039 SHALL, on simultaneous push and pop, perform both, leaving the occupancy unchanged; this is permitted even when full, because the pop frees the slot the same cycle.
REQ-040 SHALL, on simultaneous push and abort/clr_err flush, apply the flush and drop the push.
REQ-041 SHALL derive full/empty from an occupancy counter of width log2(DEPTH)+1; pointers SHALL wrap modulo DEPTH.
REQ-042 SHALL register all outputs except full and empty, which are decoded from the counter.

Reset
REQ-043 SHALL, on rst asserted at any time including mid-command, force IDLE, flush the FIFO (empty=1, full=0), and force cmd=16'h0000, send_cmd=0, done=0, err=0, err_code=00, ovfl=0, ack_cnt=0, and the timeout counter to 0.
REQ-044 SHALL, after rst deasserts, perform no launch until a new start.

Verification
REQ-045 SHALL cover a normal tour: push 16'h2000,16'h4001,16'h3002; start; answer each cmd_sent then resp=8'hA5 -> three send_cmd pulses in push order; done pulses once; ack_cnt=3; busy falls with done.
REQ-046 SHALL cover a NAK: one queued command; reply resp=8'h5A -> err=1, err_code=01, empty=0; clr_err -> IDLE, empty=1, err_code=00.
REQ-047 SHALL cover a timeout: TMO_CYCLES=100; launch and never assert cmd_sent -> ERR with err_code=10 exactly 100 cycles after WAIT_SENT entry; a cmd_sent arriving on that cycle instead -> WAIT_RESP.
REQ-048 SHALL cover overflow and the simultaneous case: DEPTH+1 pushes -> full=1, ovfl=1, last word lost; push coincident with an ACK pop while full -> full stays 1, ovfl unchanged, the new word issued last.
REQ-049 SHALL cover abort and reset: abort in WAIT_RESP -> IDLE next cycle, empty=1, no done; rst pulse mid-LAUNCH -> all outputs at reset values; a later resp_rdy is ignored.
